// File: rtl/ws2812_tx.sv
// ws2812_tx: serialises one 24-bit GRB pixel per LED onto a WS2812 chain,
// then holds the line low for the latch interval before the next frame.
//
// Ports:
//   clk           system clock, all state on the rising edge
//   reset_n       asynchronous active-low reset
//   reset_state   high while the latch interval runs (pixel buffer swap window)
//   data_request  one-cycle pulse; colours are captured at the end of the next cycle
//   new_address   one-cycle pulse in the cycle address takes a new value
//   address       index of the LED being fetched or sent
//   red_in/green_in/blue_in  pixel colour, only looked at in SAMPLE
//   DO            registered serial output to the LED chain
//
// state  | meaning
// LATCH  | DO low for RESET_CYCLES, reset_state high
// FETCH  | data_request high for one cycle
// SAMPLE | capture {green, red, blue} into the shift register
// SEND   | 24 bits MSB first, each BIT_CYCLES long
module ws2812_tx #(
    parameter int NUM_LEDS     = 16,
    parameter int T0H_CYCLES   = 20,
    parameter int T1H_CYCLES   = 40,
    parameter int BIT_CYCLES   = 63,
    parameter int RESET_CYCLES = 2600
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic                        reset_state,
    output logic                        data_request,
    output logic                        new_address,
    output logic [$clog2(NUM_LEDS)-1:0] address,
    input  logic [7:0]                  red_in,
    input  logic [7:0]                  green_in,
    input  logic [7:0]                  blue_in,
    output logic                        DO
);

    localparam int AW      = $clog2(NUM_LEDS);
    localparam int CNT_MAX = (RESET_CYCLES > BIT_CYCLES) ? RESET_CYCLES : BIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYCLES);
    localparam logic [AW-1:0] ADDR_LAST  = AW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        ST_LATCH  = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_SEND   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_idx;
    logic [23:0]   shift;

    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] high_len;

    assign cnt_nxt  = cnt + CW'(1);
    assign high_len = shift[23] ? T1H : T0H;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_LATCH;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            address      <= '0;
            DO           <= 1'b0;
            data_request <= 1'b0;
            new_address  <= 1'b0;
            reset_state  <= 1'b1;
        end else begin
            data_request <= 1'b0;
            new_address  <= 1'b0;
            case (state)
                ST_LATCH: begin
                    DO <= 1'b0;
                    if (cnt == RESET_LAST) begin
                        cnt          <= '0;
                        state        <= ST_FETCH;
                        data_request <= 1'b1;
                        reset_state  <= 1'b0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                ST_FETCH: begin
                    DO    <= 1'b0;
                    state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    shift   <= {green_in, red_in, blue_in};
                    bit_idx <= '0;
                    cnt     <= '0;
                    // First high cycle of bit 0 coincides with the first SEND cycle.
                    DO      <= 1'b1;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == 5'd23) begin
                            DO          <= 1'b0;
                            new_address <= 1'b1;
                            if (address == ADDR_LAST) begin
                                address     <= '0;
                                state       <= ST_LATCH;
                                reset_state <= 1'b1;
                            end else begin
                                address      <= address + AW'(1);
                                state        <= ST_FETCH;
                                data_request <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 5'd1;
                            shift   <= {shift[22:0], 1'b0};
                            DO      <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_nxt;
                        // DO for the cycle about to start: high while still inside the pulse.
                        DO  <= (cnt_nxt < high_len);
                    end
                end
                default: begin
                    state <= ST_LATCH;
                    DO    <= 1'b0;
                end
            endcase
        end
    end

endmodule
